// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types, constants and helpers for the machine-mode
//               interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Upper bound on the number of interrupt sources the controller supports
    localparam int c_max_src = 32;

    // Width of an index into a maximal source vector
    localparam int c_max_id_w = $clog2(c_max_src);

    // Controller FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_ACTIVE = 2'b10
    } irq_state_e;

    // Fixed-priority encoder: returns the lowest set bit index (0 when empty)
    function automatic logic [c_max_id_w-1:0] prio_enc(input logic [c_max_src-1:0] vec);
        logic [c_max_id_w-1:0] idx;
        idx = '0;
        for (int i = c_max_src - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = c_max_id_w'(i);
            end
        end
        return idx;
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_src_cell.sv
`default_nettype none
// ============================================================================
// Module      : irq_src_cell
// Description : One interrupt source: optional rising-edge detector and the
//               pending flop that feeds arbitration and mip readback.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_src_cell #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic intr_in,
    input  logic clr,
    output logic pending
);

    if (EDGE) begin : g_edge
        logic r_in_q;

        // Previous line value for rising-edge detection
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_in_q <= 1'b0;
            end else begin
                r_in_q <= intr_in;
            end
        end

        // Latch a rising edge; a new edge beats a simultaneous acknowledge clear
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pending <= 1'b0;
            end else if (intr_in && !r_in_q) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end else begin : g_level
        // Level sources are never cleared here; the peripheral drops the line
        logic w_unused_clr;
        assign w_unused_clr = clr;

        // Pending simply follows the registered line
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pending <= 1'b0;
            end else begin
                pending <= intr_in;
            end
        end
    end

endmodule : irq_src_cell
`default_nettype wire

// File: rtl/irq_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_multi
// Description : Fixed-priority machine-mode interrupt controller with a
//               request / acknowledge / complete handshake to the core.
//               One interrupt in service at a time, no nesting.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl_multi
    import irq_pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter int                 ID_W      = (NUM_SRC <= 2) ? 1 : $clog2(NUM_SRC),
    parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b0}}
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] intr_in,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic               mie_bit,
    input  logic               intr_ack,
    input  logic               intr_done,
    output logic               intr_req,
    output logic [ID_W-1:0]    intr_id,
    output logic               intr_active,
    output logic [NUM_SRC-1:0] pending
);

    irq_state_e            r_state;
    irq_state_e            w_state_nxt;
    logic                  w_req_nxt;
    logic [ID_W-1:0]       w_id_nxt;
    logic                  w_active_nxt;
    logic [NUM_SRC-1:0]    w_eligible;
    logic [NUM_SRC-1:0]    w_clr;
    logic [c_max_src-1:0]  w_elig_ext;
    logic [c_max_id_w-1:0] w_winner_full;
    logic [ID_W-1:0]       w_winner;
    logic                  w_cur_eligible;
    logic                  w_ack_taken;

    // An acknowledge only counts while a request is outstanding
    assign w_ack_taken = intr_ack && (r_state == ST_REQ);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign w_clr[i] = w_ack_taken && (intr_id == ID_W'(i));

        irq_src_cell #(
            .EDGE (EDGE_MASK[i])
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .intr_in (intr_in[i]),
            .clr     (w_clr[i]),
            .pending (pending[i])
        );
    end

    // Masks gate arbitration only; pending is recorded regardless
    assign w_eligible     = pending & src_en;
    assign w_cur_eligible = w_eligible[intr_id];

    // Widen the eligible vector so the shared encoder can be reused
    always_comb begin
        w_elig_ext              = '0;
        w_elig_ext[NUM_SRC-1:0] = w_eligible;
    end

    assign w_winner_full = prio_enc(w_elig_ext);
    assign w_winner      = w_winner_full[ID_W-1:0];

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; the ID is frozen once requested
    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = intr_req;
        w_id_nxt     = intr_id;
        w_active_nxt = intr_active;
        case (r_state)
            ST_IDLE: begin
                if (mie_bit && (|w_eligible)) begin
                    w_state_nxt = ST_REQ;
                    w_id_nxt    = w_winner;
                    w_req_nxt   = 1'b1;
                end
            end
            ST_REQ: begin
                if (intr_ack) begin
                    w_state_nxt  = ST_ACTIVE;
                    w_req_nxt    = 1'b0;
                    w_active_nxt = 1'b1;
                end else if (!mie_bit || !w_cur_eligible) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (intr_done) begin
                    w_state_nxt  = ST_IDLE;
                    w_active_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_req_nxt    = 1'b0;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs toward the core
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            intr_req    <= 1'b0;
            intr_id     <= '0;
            intr_active <= 1'b0;
        end else begin
            intr_req    <= w_req_nxt;
            intr_id     <= w_id_nxt;
            intr_active <= w_active_nxt;
        end
    end

endmodule : irq_ctrl_multi
`default_nettype wire
